// File: rtl/eth_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : eth_frame_tx
//  Purpose  : Store-and-forward Ethernet frame transmitter. Accepts payload
//             packets on an 8-bit AXI-Stream input, queues them in a data FIFO
//             with a companion length FIFO, and emits complete frames
//             (preamble, SFD, header, payload, pad, FCS, inter-frame gap) on a
//             GMII (8-bit) or MII (4-bit) transmit interface.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_frame_tx #(
   parameter int GMII_WIDTH      = 8,     // 8 = GMII byte lane, 4 = MII nibble lane
   parameter int DATA_FIFO_DEPTH = 2048,  // payload store, bytes, power of two
   parameter int LEN_FIFO_DEPTH  = 8,     // committed packets, power of two >= 2
   parameter int MAX_PAYLOAD     = 1500,  // largest accepted payload, bytes
   parameter int IFG_BYTES       = 12     // minimum inter-frame gap, byte times
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [7:0]            s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [47:0]           dst_mac_i,
   input  logic [47:0]           src_mac_i,
   input  logic [15:0]           ethertype_i,
   output logic                  tx_en_o,
   output logic [GMII_WIDTH-1:0] tx_d_o,
   output logic                  frame_sent_o,
   output logic                  frame_drop_o,
   output logic                  busy_o
);

   localparam int c_AW  = $clog2(DATA_FIFO_DEPTH);
   localparam int c_LAW = $clog2(LEN_FIFO_DEPTH);
   localparam int c_LW  = $clog2(MAX_PAYLOAD + 1);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   typedef logic [c_AW:0]  dptr_t;
   typedef logic [c_LAW:0] lptr_t;
   typedef logic [c_LW:0]  plen_t;
   typedef logic [15:0]    bcnt_t;

   localparam plen_t c_MAXP       = plen_t'(MAX_PAYLOAD);
   // Start of packet is allowed only while used space leaves MAX_PAYLOAD free.
   localparam dptr_t c_USED_LIMIT = dptr_t'(DATA_FIFO_DEPTH - MAX_PAYLOAD);
   localparam bcnt_t c_IFG_LAST   = bcnt_t'(IFG_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PREAMBLE = 3'd1,
      S_SFD      = 3'd2,
      S_HEADER   = 3'd3,
      S_PAYLOAD  = 3'd4,
      S_PAD      = 3'd5,
      S_FCS      = 3'd6,
      S_IFG      = 3'd7
   } state_t;

   // ---------------------------------------------------------------- storage
   logic [7:0] data_mem [DATA_FIFO_DEPTH];
   plen_t      len_mem  [LEN_FIFO_DEPTH];

   // ------------------------------------------------------------ write side
   dptr_t wr_ptr_q;      // speculative pointer, advances per stored byte
   dptr_t wr_commit_q;   // end of last fully committed packet
   lptr_t len_wr_q;
   plen_t in_cnt_q;      // bytes accepted so far in current packet (saturating)
   logic  in_pkt_q;      // mid-packet: tready held high regardless of space
   logic  drop_q;

   // ------------------------------------------------------------- read side
   state_t          state_q;
   bcnt_t           bcnt_q;
   logic            sub_q;     // nibble phase in MII mode
   logic [111:0]    hdr_q;
   plen_t           len_q;
   logic [31:0]     crc_q;
   dptr_t           rd_ptr_q;
   lptr_t           len_rd_q;
   logic            tx_en_q;
   logic [GMII_WIDTH-1:0] tx_d_q;
   logic            sent_q;

   logic            w_len_full;
   logic            w_len_empty;
   dptr_t           w_used;
   logic            w_acc;
   logic            w_store;
   logic            w_commit;
   logic            w_drop;
   logic            w_tick;
   logic            w_launch;
   logic            w_active;
   logic [7:0]      w_byte;
   logic [GMII_WIDTH-1:0] w_slice;

   // Reflected CRC-32 (0xEDB88320 is 0x04C11DB7 bit-reversed), one byte, LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   assign w_used      = wr_commit_q - rd_ptr_q;
   assign w_len_empty = (len_wr_q == len_rd_q);
   assign w_len_full  = (len_wr_q[c_LAW] != len_rd_q[c_LAW]) &&
                        (len_wr_q[c_LAW-1:0] == len_rd_q[c_LAW-1:0]);

   assign s_axis_tready = !rst_i && (in_pkt_q || (!w_len_full && (w_used <= c_USED_LIMIT)));
   assign w_acc    = s_axis_tvalid && s_axis_tready;
   // Bytes beyond MAX_PAYLOAD are swallowed; a packet whose last byte was not
   // stored is oversize and gets dropped at tlast.
   assign w_store  = w_acc && (in_cnt_q < c_MAXP);
   assign w_commit = w_acc && s_axis_tlast && w_store;
   assign w_drop   = w_acc && s_axis_tlast && !w_store;

   // Write-side bookkeeping: byte count, speculative/committed pointers, drop pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q    <= '0;
         wr_commit_q <= '0;
         len_wr_q    <= '0;
         in_cnt_q    <= '0;
         in_pkt_q    <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         drop_q <= w_drop;
         if (w_acc) begin
            if (s_axis_tlast) begin
               in_pkt_q <= 1'b0;
               in_cnt_q <= '0;
               if (w_store) begin
                  wr_ptr_q    <= wr_ptr_q + dptr_t'(1);
                  wr_commit_q <= wr_ptr_q + dptr_t'(1);
                  len_wr_q    <= len_wr_q + lptr_t'(1);
               end else begin
                  wr_ptr_q <= wr_commit_q;
               end
            end else begin
               in_pkt_q <= 1'b1;
               if (in_cnt_q <= c_MAXP) begin
                  in_cnt_q <= in_cnt_q + plen_t'(1);
               end
               if (w_store) begin
                  wr_ptr_q <= wr_ptr_q + dptr_t'(1);
               end
            end
         end
      end
   end

   // FIFO memories: payload bytes and committed packet lengths.
   always_ff @(posedge clk_i) begin
      if (w_store) begin
         data_mem[wr_ptr_q[c_AW-1:0]] <= s_axis_tdata;
      end
      if (w_commit) begin
         len_mem[len_wr_q[c_LAW-1:0]] <= in_cnt_q + plen_t'(1);
      end
   end

   // Lane width: a byte time is one cycle on GMII, two cycles (low nibble first) on MII.
   generate
      if (GMII_WIDTH == 8) begin : g_gmii8
         assign w_tick  = 1'b1;
         assign w_slice = w_byte;
      end else begin : g_mii4
         assign w_tick  = sub_q;
         assign w_slice = sub_q ? w_byte[7:4] : w_byte[3:0];
      end
   endgenerate

   assign w_active = (state_q != S_IDLE) && (state_q != S_IFG);
   // A new frame may start from IDLE or directly at the end of the gap so the
   // gap between back-to-back frames is exactly IFG_BYTES.
   assign w_launch = !w_len_empty &&
                     ((state_q == S_IDLE) ||
                      ((state_q == S_IFG) && w_tick && (bcnt_q == c_IFG_LAST)));

   // Byte presented on the line during the current byte time.
   always_comb begin
      w_byte = 8'h00;
      case (state_q)
         S_PREAMBLE: w_byte = 8'h55;
         S_SFD:      w_byte = 8'hD5;
         S_HEADER:   w_byte = hdr_q[111:104];
         S_PAYLOAD:  w_byte = data_mem[rd_ptr_q[c_AW-1:0]];
         S_FCS:      w_byte = ~crc_q[7:0];
         default:    w_byte = 8'h00;
      endcase
   end

   // Transmit FSM with CRC accumulation, FIFO reads and registered line outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         bcnt_q   <= '0;
         sub_q    <= 1'b0;
         hdr_q    <= '0;
         len_q    <= '0;
         crc_q    <= 32'hFFFF_FFFF;
         rd_ptr_q <= '0;
         len_rd_q <= '0;
         tx_en_q  <= 1'b0;
         tx_d_q   <= '0;
         sent_q   <= 1'b0;
      end else begin
         tx_en_q <= w_active;
         tx_d_q  <= w_active ? w_slice : '0;
         sent_q  <= 1'b0;
         if (state_q != S_IDLE) begin
            sub_q <= ~sub_q;
         end
         if (w_tick && ((state_q == S_HEADER) || (state_q == S_PAYLOAD) || (state_q == S_PAD))) begin
            crc_q <= crc32_byte(crc_q, w_byte);
         end

         if (w_launch) begin
            state_q <= S_PREAMBLE;
            bcnt_q  <= '0;
            sub_q   <= 1'b0;
            hdr_q   <= {dst_mac_i, src_mac_i, ethertype_i};
            len_q   <= len_mem[len_rd_q[c_LAW-1:0]];
            crc_q   <= 32'hFFFF_FFFF;
         end else if (w_tick) begin
            case (state_q)
               S_PREAMBLE: begin
                  if (bcnt_q == bcnt_t'(6)) begin
                     state_q <= S_SFD;
                     bcnt_q  <= '0;
                  end else begin
                     bcnt_q <= bcnt_q + bcnt_t'(1);
                  end
               end
               S_SFD: begin
                  state_q <= S_HEADER;
                  bcnt_q  <= '0;
               end
               S_HEADER: begin
                  hdr_q <= hdr_q << 8;
                  if (bcnt_q == bcnt_t'(13)) begin
                     state_q <= S_PAYLOAD;
                     bcnt_q  <= '0;
                  end else begin
                     bcnt_q <= bcnt_t'(bcnt_q + bcnt_t'(1));
                  end
               end
               S_PAYLOAD: begin
                  rd_ptr_q <= rd_ptr_q + dptr_t'(1);
                  if (bcnt_q == '0) begin
                     len_rd_q <= len_rd_q + lptr_t'(1);
                  end
                  // Counter keeps running into PAD so both end at byte 45.
                  if (bcnt_q == bcnt_t'(len_q) - bcnt_t'(1)) begin
                     if (bcnt_q < bcnt_t'(45)) begin
                        state_q <= S_PAD;
                        bcnt_q  <= bcnt_q + bcnt_t'(1);
                     end else begin
                        state_q <= S_FCS;
                        bcnt_q  <= '0;
                     end
                  end else begin
                     bcnt_q <= bcnt_q + bcnt_t'(1);
                  end
               end
               S_PAD: begin
                  if (bcnt_q == bcnt_t'(45)) begin
                     state_q <= S_FCS;
                     bcnt_q  <= '0;
                  end else begin
                     bcnt_q <= bcnt_q + bcnt_t'(1);
                  end
               end
               S_FCS: begin
                  // Shift so the next FCS byte is always in crc_q[7:0].
                  crc_q <= {8'h00, crc_q[31:8]};
                  if (bcnt_q == bcnt_t'(3)) begin
                     state_q <= S_IFG;
                     bcnt_q  <= '0;
                     sent_q  <= 1'b1;
                  end else begin
                     bcnt_q <= bcnt_q + bcnt_t'(1);
                  end
               end
               S_IFG: begin
                  if (bcnt_q == c_IFG_LAST) begin
                     state_q <= S_IDLE;
                     bcnt_q  <= '0;
                  end else begin
                     bcnt_q <= bcnt_q + bcnt_t'(1);
                  end
               end
               default: begin
                  bcnt_q <= '0;
               end
            endcase
         end
      end
   end

   assign tx_en_o      = tx_en_q;
   assign tx_d_o       = tx_d_q;
   assign frame_sent_o = sent_q;
   assign frame_drop_o = drop_q;
   assign busy_o       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_frame_tx
//  Purpose  : Directed self-checking bench for eth_frame_tx (GMII and MII).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eth_frame_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [7:0]  tdata = 8'h00;
   logic        tlast = 1'b0;
   logic        tvalid8 = 1'b0, tvalid4 = 1'b0;
   logic        tready8, tready4;
   logic [47:0] dst_mac = 48'h1122_3344_5566;
   logic [47:0] src_mac = 48'hA0B1_C2D3_E4F5;
   logic [15:0] etype   = 16'h0800;
   logic        tx_en8, tx_en4;
   logic [7:0]  tx_d8;
   logic [3:0]  tx_d4;
   logic        sent8, sent4, drop8, drop4, busy8, busy4;

   eth_frame_tx #(.GMII_WIDTH(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid8), .s_axis_tready(tready8), .s_axis_tlast(tlast),
      .dst_mac_i(dst_mac), .src_mac_i(src_mac), .ethertype_i(etype),
      .tx_en_o(tx_en8), .tx_d_o(tx_d8),
      .frame_sent_o(sent8), .frame_drop_o(drop8), .busy_o(busy8)
   );

   eth_frame_tx #(.GMII_WIDTH(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid4), .s_axis_tready(tready4), .s_axis_tlast(tlast),
      .dst_mac_i(dst_mac), .src_mac_i(src_mac), .ethertype_i(etype),
      .tx_en_o(tx_en4), .tx_d_o(tx_d4),
      .frame_sent_o(sent4), .frame_drop_o(drop4), .busy_o(busy4)
   );

   // ------------------------------------------------------------ line monitors
   logic [7:0] cap8[$];
   logic [3:0] capn4[$];
   int run8 = 0, lastrun8 = 0, low8 = 0, gap8 = 0, nfr8 = 0, nsent8 = 0, ndrop8 = 0, idle_bad8 = 0;
   int run4 = 0, lastrun4 = 0, low4 = 0, gap4 = 0, nfr4 = 0, nsent4 = 0, ndrop4 = 0, idle_bad4 = 0;

   always @(negedge clk) begin
      if (tx_en8) begin
         cap8.push_back(tx_d8);
         if (run8 == 0) gap8 = low8;
         run8++;
         low8 = 0;
      end else begin
         if (run8 != 0) begin lastrun8 = run8; nfr8++; run8 = 0; end
         low8++;
         if (tx_d8 != 8'h00) idle_bad8++;
      end
      if (sent8) nsent8++;
      if (drop8) ndrop8++;
   end

   always @(negedge clk) begin
      if (tx_en4) begin
         capn4.push_back(tx_d4);
         if (run4 == 0) gap4 = low4;
         run4++;
         low4 = 0;
      end else begin
         if (run4 != 0) begin lastrun4 = run4; nfr4++; run4 = 0; end
         low4++;
         if (tx_d4 != 4'h0) idle_bad4++;
      end
      if (sent4) nsent4++;
      if (drop4) ndrop4++;
   end

   // --------------------------------------------------------------- checking
   int n_checks = 0, n_pass = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------- reference model
   logic [7:0] expq[$];

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int b = 0; b < 32; b++) r[b] = v[31-b];
      return r;
   endfunction

   function automatic logic [7:0] pbyte(input int base, input int step, input int i);
      int v;
      v = base + i * step;
      return v[7:0];
   endfunction

   // Appends one complete expected frame (preamble through FCS) to expq.
   task automatic add_expected(input int n, input int base, input int step);
      logic [7:0]   body[$];
      logic [31:0]  crc;
      logic [111:0] hdr;
      hdr = {dst_mac, src_mac, etype};
      for (int k = 0; k < 14; k++) body.push_back(hdr[111-8*k -: 8]);
      for (int i = 0; i < n; i++) body.push_back(pbyte(base, step, i));
      for (int i = n; i < 46; i++) body.push_back(8'h00);
      crc = 32'hFFFF_FFFF;
      foreach (body[k]) crc = crc_step(crc, body[k]);
      crc = ~crc;
      for (int k = 0; k < 7; k++) expq.push_back(8'h55);
      expq.push_back(8'hD5);
      foreach (body[k]) expq.push_back(body[k]);
      for (int k = 0; k < 4; k++) expq.push_back(crc[8*k +: 8]);
   endtask

   function automatic logic [7:0] get_byte(input int dut, input int start, input int k);
      if (dut == 8) return cap8[start + k];
      return {capn4[start + 2*k + 1], capn4[start + 2*k]};
   endfunction

   function automatic int avail_bytes(input int dut, input int start);
      if (dut == 8) return cap8.size() - start;
      return (capn4.size() - start) / 2;
   endfunction

   function automatic int mism(input int dut, input int start);
      int m, n;
      m = 0;
      n = avail_bytes(dut, start);
      if (n > expq.size()) n = expq.size();
      for (int k = 0; k < n; k++) if (get_byte(dut, start, k) !== expq[k]) m++;
      return m;
   endfunction

   // CRC register run over header..FCS of one frame; bit-reversed to match the
   // conventional 0xC704DD7B residue constant.
   function automatic logic [31:0] residue(input int dut, input int start, input int flen);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int k = 8; k < flen; k++) c = crc_step(c, get_byte(dut, start, k));
      return bitrev32(c);
   endfunction

   // ------------------------------------------------------------- stimulus
   task automatic send_pkt(input int dut, input int n, input int base, input int step);
      int i, guard;
      logic rdy;
      i = 0;
      guard = 0;
      while (i < n && guard < 5000) begin
         @(negedge clk);
         tdata = pbyte(base, step, i);
         tlast = (i == n - 1);
         if (dut == 8) tvalid8 = 1'b1; else tvalid4 = 1'b1;
         rdy = (dut == 8) ? tready8 : tready4;
         @(posedge clk);
         if (rdy) i++; else guard++;
      end
      @(negedge clk);
      tvalid8 = 1'b0;
      tvalid4 = 1'b0;
      tlast   = 1'b0;
      chk($sformatf("send%0d_len%0d", dut, n), i, n);
   endtask

   task automatic wait_fr(input int dut, input int target, input int budget);
      int c;
      c = 0;
      while (((dut == 8) ? nfr8 : nfr4) < target && c < budget) begin
         @(negedge clk); #1;
         c++;
      end
      chk($sformatf("frames%0d", dut), (dut == 8) ? nfr8 : nfr4, target);
   endtask

   initial begin
      int b0, f0, s0, d0, c;

      // ---- reset state
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_tready", tready8, 0);
      chk("rst_tx_en", tx_en8, 0);
      chk("rst_tx_d", tx_d8, 0);
      chk("rst_busy", busy8, 0);
      chk("rst_sent_drop", {sent8, drop8}, 0);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("idle_tready", tready8, 1);

      // ---- 64-byte frame, header inputs disturbed mid-frame
      expq.delete();
      b0 = cap8.size(); f0 = nfr8; s0 = nsent8;
      add_expected(64, 0, 1);
      send_pkt(8, 64, 0, 1);
      c = 0;
      while (!busy8 && c < 20) begin @(negedge clk); #1; c++; end
      chk("busy_in_frame", busy8, 1);
      dst_mac = 48'hDEAD_BEEF_0001; src_mac = 48'h0000_0000_0002; etype = 16'h86DD;
      wait_fr(8, f0 + 1, 400);
      dst_mac = 48'h1122_3344_5566; src_mac = 48'hA0B1_C2D3_E4F5; etype = 16'h0800;
      chk("f64_run", lastrun8, 90);
      chk("f64_len", avail_bytes(8, b0), 90);
      chk("f64_stream", mism(8, b0), 0);
      chk("f64_sfd", get_byte(8, b0, 7), 8'hD5);
      chk("f64_residue", residue(8, b0, 90), 32'hC704_DD7B);
      chk("f64_sent", nsent8 - s0, 1);

      // ---- 10-byte payload, padded to 46
      expq.delete();
      b0 = cap8.size(); f0 = nfr8;
      add_expected(10, 8'hA0, 3);
      send_pkt(8, 10, 8'hA0, 3);
      wait_fr(8, f0 + 1, 300);
      chk("f10_run", lastrun8, 72);
      chk("f10_stream", mism(8, b0), 0);
      chk("f10_pad0", get_byte(8, b0, 32), 8'h00);
      chk("f10_residue", residue(8, b0, 72), 32'hC704_DD7B);

      // ---- two 100-byte packets back to back
      expq.delete();
      b0 = cap8.size(); f0 = nfr8; s0 = nsent8;
      add_expected(100, 5, 1);
      add_expected(100, 200, 7);
      send_pkt(8, 100, 5, 1);
      send_pkt(8, 100, 200, 7);
      wait_fr(8, f0 + 2, 1000);
      chk("b2b_gap", gap8, 12);
      chk("b2b_run", lastrun8, 126);
      chk("b2b_stream", mism(8, b0), 0);
      chk("b2b_len", avail_bytes(8, b0), 252);
      chk("b2b_sent", nsent8 - s0, 2);

      // ---- oversize packet dropped, following packet sent
      expq.delete();
      b0 = cap8.size(); f0 = nfr8; s0 = nsent8; d0 = ndrop8;
      add_expected(20, 8'h40, 1);
      send_pkt(8, 1501, 0, 1);
      send_pkt(8, 20, 8'h40, 1);
      wait_fr(8, f0 + 1, 500);
      repeat (100) @(negedge clk);
      #1;
      chk("drop_pulse", ndrop8 - d0, 1);
      chk("drop_frames", nfr8, f0 + 1);
      chk("drop_run", lastrun8, 72);
      chk("drop_stream", mism(8, b0), 0);
      chk("drop_sent", nsent8 - s0, 1);

      // ---- MII: two 46-byte packets
      expq.delete();
      b0 = capn4.size(); f0 = nfr4; s0 = nsent4;
      add_expected(46, 8'h11, 5);
      add_expected(46, 8'h77, 1);
      send_pkt(4, 46, 8'h11, 5);
      send_pkt(4, 46, 8'h77, 1);
      wait_fr(4, f0 + 2, 2000);
      chk("mii_run", lastrun4, 144);
      chk("mii_gap", gap4, 24);
      chk("mii_sfd_lo", capn4[b0 + 14], 4'h5);
      chk("mii_sfd_hi", capn4[b0 + 15], 4'hD);
      chk("mii_stream", mism(4, b0), 0);
      chk("mii_residue", residue(4, b0, 72), 32'hC704_DD7B);
      chk("mii_sent", nsent4 - s0, 2);

      // ---- reset in the middle of the payload
      expq.delete();
      s0 = nsent8;
      send_pkt(8, 64, 8'h33, 1);
      c = 0;
      while (run8 < 42 && c < 300) begin @(negedge clk); #1; c++; end
      chk("mid_reached", run8, 42);
      rst = 1'b1;
      #1;
      chk("mid_rst_tready", tready8, 0);
      @(negedge clk); #1;
      chk("mid_rst_tx_en", tx_en8, 0);
      chk("mid_rst_busy", busy8, 0);
      rst = 1'b0;
      f0 = nfr8;
      repeat (200) @(negedge clk);
      #1;
      chk("mid_no_resume", nfr8, f0);
      chk("mid_no_sent", nsent8, s0);
      b0 = cap8.size();
      add_expected(64, 8'h80, 1);
      send_pkt(8, 64, 8'h80, 1);
      wait_fr(8, f0 + 1, 400);
      chk("post_rst_run", lastrun8, 90);
      chk("post_rst_stream", mism(8, b0), 0);
      chk("post_rst_residue", residue(8, b0, 90), 32'hC704_DD7B);

      chk("idle_zero8", idle_bad8, 0);
      chk("idle_zero4", idle_bad4, 0);
      chk("no_drop4", ndrop4, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/eth_frame_tx.md
ETH_FRAME_TX -- requirements
Module: eth_frame_tx

Interface
REQ-001 SHALL have parameter GMII_WIDTH, default 8, meaning output nibble/byte width; legal values 4 and 8 only.
REQ-002 SHALL have parameter DATA_FIFO_DEPTH, default 2048, meaning payload store depth in bytes (power of two).
REQ-003 SHALL have parameter LEN_FIFO_DEPTH, default 8, meaning max committed packets queued.
REQ-004 SHALL have parameter MAX_PAYLOAD, default 1500, meaning largest accepted payload in bytes.
REQ-005 SHALL have parameter IFG_BYTES, default 12, meaning minimum inter-frame gap in byte times.
REQ-006 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset.
REQ-007 SHALL have ports: s_axis_tdata in 8; s_axis_tvalid in 1; s_axis_tready out 1; s_axis_tlast in 1 (payload stream, one packet per tlast).
REQ-008 SHALL have ports: dst_mac_i in 48; src_mac_i in 48; ethertype_i in 16 (header fields).
REQ-009 SHALL have ports: tx_en_o out 1; tx_d_o out GMII_WIDTH (GMII/MII transmit).
REQ-010 SHALL have ports: frame_sent_o out 1 pulse; frame_drop_o out 1 pulse; busy_o out 1 (state != IDLE).
REQ-011 SHALL use one clock clk_i; rst_i is synchronous, active-high.

Function
REQ-012 SHALL operate store-and-forward: transmission of a packet starts only after its tlast byte is written and its length is committed to the length FIFO.
REQ-013 SHALL drive s_axis_tready = 1 mid-packet, and at packet start only when length FIFO not full and data FIFO free space >= MAX_PAYLOAD.
REQ-014 SHALL count payload bytes per packet; on tlast commit count to length FIFO and advance committed write pointer.
REQ-015 SHALL, when byte count exceeds MAX_PAYLOAD, keep accepting bytes without storing, rewind write pointer to packet start on tlast, commit nothing, pulse frame_drop_o one cycle on the tlast handshake.
REQ-016 SHALL implement FSM IDLE -> PREAMBLE (7 bytes 0x55) -> SFD (0xD5) -> HEADER (14 bytes) -> PAYLOAD (N bytes) -> PAD (max(0,46-N) bytes 0x00) -> FCS (4 bytes) -> IFG (IFG_BYTES) -> IDLE.
REQ-017 SHALL leave IDLE when length FIFO non-empty; sample dst_mac_i, src_mac_i, ethertype_i on that transition and hold them for the frame.
REQ-018 SHALL skip PAD when N >= 46 (PAYLOAD -> FCS directly).
REQ-019 SHALL send header bytes in order dst MAC [47:40] first ... src MAC ... ethertype [15:8] then [7:0].
REQ-020 SHALL, for GMII_WIDTH=4, send each byte as two cycles, bits [3:0] then [7:4]; every state lasts bytes*8/GMII_WIDTH cycles.
REQ-021 SHALL compute CRC-32 (poly 0x04C11DB7 reflected, init 0xFFFFFFFF, output inverted) over HEADER, PAYLOAD and PAD; transmit FCS least-significant byte first.
REQ-022 SHALL pop length FIFO and payload bytes only in PAYLOAD state, one byte per byte time, with no bubbles.
REQ-023 SHALL register outputs: tx_en_o/tx_d_o reflect state one cycle later; tx_en_o high for PREAMBLE through FCS, low in IDLE/IFG with tx_d_o = 0.
REQ-024 SHALL pulse frame_sent_o one cycle on FCS -> IFG transition.
REQ-025 SHALL, with writes and reads in the same cycle, update FIFO occupancy by both (no lost or duplicated bytes); pointers wrap modulo depth.
REQ-026 SHALL ignore header input changes mid-frame.

Reset
REQ-027 SHALL on rst_i: FSM -> IDLE, both FIFOs empty, partial packet discarded, CRC -> 0xFFFFFFFF, tx_en_o = 0, tx_d_o = 0, frame_sent_o = 0, frame_drop_o = 0, busy_o = 0, s_axis_tready = 0 during reset.
REQ-028 SHALL, on reset mid-frame, drop tx_en_o to 0 the cycle after rst_i is sampled and never resume that frame.

Verification
REQ-029 SHALL cover: GMII_WIDTH=8, 64-byte payload 0x00..0x3F -> tx_en_o high 90 consecutive cycles, 7x0x55, 0xD5, header, payload, CRC residue over frame+FCS = 0xC704DD7B, one frame_sent_o pulse.
REQ-030 SHALL cover: 10-byte payload -> 36 pad bytes 0x00, tx_en_o high 72 cycles, valid FCS.
REQ-031 SHALL cover: two 100-byte packets queued back-to-back -> tx_en_o low exactly 12 cycles between frames.
REQ-032 SHALL cover: 1501-byte packet then 20-byte packet -> frame_drop_o one pulse, only the 20-byte frame transmitted (tx_en_o high 72 cycles).
REQ-033 SHALL cover: GMII_WIDTH=4, 46-byte payload -> SFD as 0x5 then 0xD, tx_en_o high 144 cycles, IFG 24 cycles.
REQ-034 SHALL cover: rst_i asserted at PAYLOAD byte 20 -> tx_en_o = 0 next cycle, busy_o = 0, then fresh 64-byte packet transmits correctly.
